swap_pair_loader: RTL and testbench
===================================

Name: swap_pair_loader

Overview:
Upstream operand stage for the clocked 8-bit swap register. It collects a serial byte stream into an (a, b) operand pair over a valid/ready handshake. It presents the pair on registered outputs that stay stable until the next complete pair, and hands each completed pair off with a pair_valid/pair_ready handshake. It also keeps a count of pairs delivered.

Parameters:
WIDTH, 8, width of each operand and of in_data
CNT_WIDTH, 8, width of the delivered-pair counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  serial operand byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader can accept in_data this cycle
flush  input  1  synchronous discard of any partial pair
a  output  WIDTH  first operand of last completed pair (registered)
b  output  WIDTH  second operand of last completed pair (registered)
pair_valid  output  1  a/b hold a new pair not yet consumed
pair_ready  input  1  downstream swap stage takes the pair
pair_count  output  CNT_WIDTH  number of pairs handed off, wraps

Behaviour:
- Reset (rst_n low, asynchronous): state=LOAD_A, a=0, b=0, pair_valid=0, pair_count=0, in_ready=1, staging register=0. Effective immediately and mid-pair; any partial pair is lost.
- Beat accepted when in_valid && in_ready at a rising edge.
- FSM states:
  - LOAD_A: in_ready=1. An accepted beat goes to the staging register; next state LOAD_B.
  - LOAD_B: in_ready=1. An accepted beat loads a<=staging and b<=in_data on the same edge. pair_valid<=1. Next state HOLD.
  - HOLD: in_ready=0 and pair_valid=1. When pair_ready=1 at an edge: pair_valid<=0, pair_count<=pair_count+1 (mod 2^CNT_WIDTH), next state LOAD_A.
- a and b change only on the LOAD_B accept edge. They are never cleared by handoff or flush. The swap stage always sees a stable pair.
- Latency: a/b/pair_valid update on the edge that accepts the second beat, so they are visible the following cycle. Minimum 3 cycles per pair: A, B, handoff.
- pair_ready while pair_valid=0 is ignored; the counter does not change.
- flush=1 at an edge:
  - In LOAD_A or LOAD_B: return to LOAD_A and discard staging. A beat presented on the same cycle is dropped, but in_ready stays 1, so the upstream considers it consumed.
  - In HOLD: no effect. The completed pair is never discarded.
- flush and pair_ready together in HOLD: the handoff proceeds normally.
- in_valid with X data while in_ready=0 must not disturb state.
- pair_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Test Plan:
1. Reset, then beats 0xAA, 0x55 on consecutive cycles, pair_ready=1 → a=0xAA and b=0x55 one cycle after the second beat; pair_valid high 1 cycle; pair_count=1. A downstream swap register shows a_swapped=0x55, b_swapped=0xAA.
2. Load 0x12, 0x34 with pair_ready=0 for 5 cycles, offering 0x99 meanwhile → in_ready=0 throughout; a/b stay 0x12/0x34; 0x99 is accepted only after pair_ready=1 lands the handoff.
3. Beat 0x01, then flush, then beats 0x02, 0x03 → pair is a=0x02, b=0x03; the 0x01 never appears.
4. Assert rst_n low asynchronously mid-HOLD with a=0x7F → a, b, pair_valid and pair_count go to 0 without waiting for a clock edge; after release the FSM starts in LOAD_A.
5. Deliver 256 pairs back-to-back with CNT_WIDTH=8 → pair_count reads 0 after the 256th handoff, and 1 after the 257th.
6. Flush and pair_ready together in HOLD → handoff happens and pair_count increments; a/b unchanged.

Source files
------------

// File: rtl/swap_pair_loader.sv
// Collects a serial byte stream into an (a, b) operand pair for the swap register.
// Completed pairs are held stable and handed off over a pair_valid/pair_ready handshake.
module swap_pair_loader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic [CNT_WIDTH-1:0] pair_count
);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] staging;
  logic             accept;
  logic             load_first;
  logic             load_pair;
  logic             handoff;
  logic             discard;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // A flush wins over a beat in the same cycle; a held pair is immune to flush.
  assign discard    = flush && (state != HOLD);
  assign load_first = (state == LOAD_A) && accept && !flush;
  assign load_pair  = (state == LOAD_B) && accept && !flush;
  assign handoff    = (state == HOLD) && pair_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD_A: begin
        if (flush) begin
          next_state = LOAD_A;
        end else if (accept) begin
          next_state = LOAD_B;
        end
      end
      LOAD_B: begin
        if (flush) begin
          next_state = LOAD_A;
        end else if (accept) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (pair_ready) begin
          next_state = LOAD_A;
        end
      end
      default: next_state = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (discard) begin
      staging <= '0;
    end else if (load_first) begin
      staging <= in_data;
    end
  end

  // a/b only ever change when a full pair lands, so the swap stage sees a stable pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      pair_valid <= 1'b0;
      pair_count <= '0;
    end else begin
      if (load_pair) begin
        a          <= staging;
        b          <= in_data;
        pair_valid <= 1'b1;
      end else if (handoff) begin
        pair_valid <= 1'b0;
        pair_count <= pair_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_swap_pair_loader.sv
// Directed self-checking bench for swap_pair_loader: handshake, stall, flush,
// async reset, counter wrap and flush/handoff collision.
module tb_swap_pair_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] a;
  logic [7:0] b;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] pair_count;

  int n_compared;
  int n_mismatched;

  swap_pair_loader #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic fl, input logic pready);
    in_valid   = valid;
    in_data    = data;
    flush      = fl;
    pair_ready = pready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPair(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic epv, input logic [7:0] ecnt);
    checkOutput({tag, "_a"}, {24'd0, a}, {24'd0, ea});
    checkOutput({tag, "_b"}, {24'd0, b}, {24'd0, eb});
    checkOutput({tag, "_pv"}, {31'd0, pair_valid}, {31'd0, epv});
    checkOutput({tag, "_cnt"}, {24'd0, pair_count}, {24'd0, ecnt});
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    flush      = 1'b0;
    pair_ready = 1'b0;
    #3;
    checkPair("reset", 8'h00, 8'h00, 1'b0, 8'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] test 1: basic pair");
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    checkPair("t1_after_a", 8'h00, 8'h00, 1'b0, 8'd0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkPair("t1_loaded", 8'hAA, 8'h55, 1'b1, 8'd0);
    checkOutput("t1_in_ready_hold", {31'd0, in_ready}, 32'd0);
    checkOutput("t1_swapped_a", {24'd0, b}, 32'h55);
    checkOutput("t1_swapped_b", {24'd0, a}, 32'hAA);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkPair("t1_handoff", 8'hAA, 8'h55, 1'b0, 8'd1);

    $display("[TB] test 2: downstream stall");
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkOutput("t2_in_ready_stall", {31'd0, in_ready}, 32'd0);
      checkPair("t2_stall", 8'h12, 8'h34, 1'b1, 8'd1);
    end
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkPair("t2_handoff", 8'h12, 8'h34, 1'b0, 8'd2);
    checkOutput("t2_in_ready_back", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkPair("t2_next_pair", 8'h99, 8'h77, 1'b1, 8'd2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkPair("t2_handoff2", 8'h99, 8'h77, 1'b0, 8'd3);

    $display("[TB] test 3: flush of partial pair");
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("t3_in_ready_flush", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    checkOutput("t3_no_pair_yet", {31'd0, pair_valid}, 32'd0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    checkPair("t3_pair", 8'h02, 8'h03, 1'b1, 8'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkPair("t3_handoff", 8'h02, 8'h03, 1'b0, 8'd4);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkPair("t3_idle_ready", 8'h02, 8'h03, 1'b0, 8'd4);

    $display("[TB] test 6: flush in HOLD");
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkPair("t6_flush_hold", 8'h5A, 8'hC3, 1'b1, 8'd4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkPair("t6_flush_handoff", 8'h5A, 8'hC3, 1'b0, 8'd5);

    $display("[TB] test 4: async reset in HOLD");
    applyStimulus(1'b1, 8'h7F, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hxx, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hxx, 1'b0, 1'b0);
    checkPair("t4_x_hold", 8'h7F, 8'h01, 1'b1, 8'd5);
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    checkPair("t4_async", 8'h00, 8'h00, 1'b0, 8'd0);
    checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
    checkPair("t4_after_reset", 8'h10, 8'h20, 1'b1, 8'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkPair("t4_handoff", 8'h10, 8'h20, 1'b0, 8'd1);

    $display("[TB] test 5: counter wrap");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
      applyStimulus(1'b1, ~8'(i), 1'b0, 1'b1);
      checkOutput("t5_a", {24'd0, a}, {24'd0, 8'(i)});
      checkOutput("t5_b", {24'd0, b}, {24'd0, ~8'(i)});
      applyStimulus(1'b1, ~8'(i), 1'b0, 1'b1);
      if (i == 254) checkOutput("t5_cnt_255", {24'd0, pair_count}, 32'd255);
      if (i == 255) checkOutput("t5_cnt_wrap", {24'd0, pair_count}, 32'd0);
      if (i == 256) checkOutput("t5_cnt_257", {24'd0, pair_count}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
